// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: arms from software, keeps a pre-trigger history in a circular
// BRAM record, detects the trigger and completes a record of programmable length.
module adc_capture_ctrl #(
    parameter int C_AddrBits = 14,
    parameter int C_SmplBits = 16
) (
    input  logic                    AdcFrmClk,
    input  logic                    SysRst,
    input  logic                    AdcDataValid,
    input  logic [8*C_SmplBits-1:0] AdcData,
    input  logic                    CfgArm,
    input  logic                    CfgAbort,
    input  logic [C_AddrBits-1:0]   CfgLength,
    input  logic [C_AddrBits-1:0]   CfgPreTrig,
    input  logic [1:0]              CfgTrigMode,
    input  logic [2:0]              CfgTrigChnl,
    input  logic [15:0]             CfgTrigLevel,
    input  logic                    ExtTrig,
    output logic [C_AddrBits-1:0]   BramAddr,
    output logic [8*C_SmplBits-1:0] BramDin,
    output logic                    BramWe,
    output logic                    CapBusy,
    output logic                    CapDone,
    output logic                    CapErr,
    output logic [C_AddrBits-1:0]   TrigAddr
);

    localparam int DW = 8 * C_SmplBits;
    localparam int CW = (C_SmplBits > 16) ? C_SmplBits : 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] MODE_IMM  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;

    function automatic logic signed [CW-1:0] sext_smp(input logic signed [C_SmplBits-1:0] v);
        return CW'(v);
    endfunction

    function automatic logic signed [CW-1:0] sext_lvl(input logic signed [15:0] v);
        return CW'(v);
    endfunction

    function automatic logic [C_AddrBits-1:0] sat_pretrig(input logic [C_AddrBits-1:0] p,
                                                          input logic [C_AddrBits-1:0] len);
        return (p > len) ? len : p;
    endfunction

    logic                  arm_s1, arm_s2, arm_pls_q;
    logic                  abt_s1, abt_s2;
    logic [2:0]            state_q;
    logic [C_AddrBits-1:0] len_q, peff_q, rem_q, addr_q, trig_addr_q;
    logic [1:0]            mode_q;
    logic [2:0]            chnl_q;
    logic                  prev_vld_q, err_q, busy_q, done_q;
    logic signed [CW-1:0]  level_q, prev_q;

    logic [DW-1:0]         din_p1;
    logic                  vld_p1;
    logic [C_AddrBits-1:0] addr_p1;

    logic signed [C_SmplBits-1:0] lane_p0 [8];
    logic signed [CW-1:0]  sel_p0;
    logic [C_AddrBits-1:0] peff_in, addr_inc_p0, post_n_p0;
    logic                  busy_p0, vld_p0, trig_p0, arm_go_p0;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign lane_p0[g] = AdcData[g*C_SmplBits +: C_SmplBits];
    end

    // Stage p0: decide on the sample currently on AdcData
    always_comb begin
        peff_in     = sat_pretrig(CfgPreTrig, CfgLength);
        busy_p0     = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
        vld_p0      = busy_p0 && AdcDataValid && !abt_s2;
        arm_go_p0   = arm_pls_q && !abt_s2 && !busy_p0;
        sel_p0      = sext_smp(lane_p0[chnl_q]);
        addr_inc_p0 = (addr_q == len_q) ? '0 : addr_q + 1'b1;
        post_n_p0   = len_q - peff_q;
        case (mode_q)
            MODE_IMM:  trig_p0 = 1'b1;
            MODE_RISE: trig_p0 = prev_vld_q && (prev_q < level_q) && (sel_p0 >= level_q);
            MODE_FALL: trig_p0 = prev_vld_q && (prev_q >= level_q) && (sel_p0 < level_q);
            default:   trig_p0 = ExtTrig;
        endcase
    end

    // Threshold and previous-sample history carry no reset; prev_vld_q guards their use
    always_ff @(posedge AdcFrmClk) begin
        if (arm_go_p0)
            level_q <= sext_lvl(CfgTrigLevel);
        if (vld_p0 && (state_q == ST_WAIT))
            prev_q <= sel_p0;
    end

    always_ff @(posedge AdcFrmClk or posedge SysRst) begin
        if (SysRst) begin
            arm_s1      <= 1'b0;
            arm_s2      <= 1'b0;
            arm_pls_q   <= 1'b0;
            abt_s1      <= 1'b0;
            abt_s2      <= 1'b0;
            state_q     <= ST_IDLE;
            len_q       <= '0;
            peff_q      <= '0;
            rem_q       <= '0;
            addr_q      <= '0;
            trig_addr_q <= '0;
            mode_q      <= '0;
            chnl_q      <= '0;
            prev_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_p1      <= '0;
            vld_p1      <= 1'b0;
            addr_p1     <= '0;
        end else begin
            arm_s1    <= CfgArm;
            arm_s2    <= arm_s1;
            arm_pls_q <= arm_s1 & ~arm_s2;
            abt_s1    <= CfgAbort;
            abt_s2    <= abt_s1;

            // Stage p1: BRAM write port, one cycle behind the sample
            din_p1  <= AdcData;
            vld_p1  <= vld_p0;
            addr_p1 <= addr_q;
            busy_q  <= busy_p0;
            done_q  <= (state_q == ST_DONE);

            if (vld_p0)
                addr_q <= addr_inc_p0;

            if (abt_s2) begin
                state_q <= ST_IDLE;
            end else if (busy_p0 && !AdcDataValid) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm_pls_q) begin
                            len_q      <= CfgLength;
                            peff_q     <= peff_in;
                            rem_q      <= peff_in;
                            mode_q     <= CfgTrigMode;
                            chnl_q     <= CfgTrigChnl;
                            addr_q     <= '0;
                            err_q      <= 1'b0;
                            prev_vld_q <= 1'b0;
                            state_q    <= (peff_in == '0) ? ST_WAIT : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == C_AddrBits'(1))
                            state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        prev_vld_q <= 1'b1;
                        if (trig_p0) begin
                            trig_addr_q <= addr_q;
                            rem_q       <= post_n_p0;
                            state_q     <= (post_n_p0 == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == C_AddrBits'(1))
                            state_q <= ST_DONE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign BramAddr = addr_p1;
    assign BramDin  = din_p1;
    assign BramWe   = vld_p1;
    assign CapBusy  = busy_q;
    assign CapDone  = done_q;
    assign CapErr   = err_q;
    assign TrigAddr = trig_addr_q;

endmodule
